demux2_buf: RTL and testbench
=============================

# demux2_buf

Registered 1:2 stream demultiplexer. Accepts one valid/ready input stream and steers each beat, according to a per-beat select, into one of two output streams. Each output has its own one-entry holding register, so the two outputs stall independently. It is the steering counterpart to the 2:1 mux cell and sits wherever a producer feeds two consumers, such as splitting a request stream between two units.

## Interface
- BITS, default 1: width of the data path.
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  reset: one clock; reset is asynchronous and active-low.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts the input beat this cycle.
- in_data  input  BITS  input payload.
- in_select  input  1  destination of the beat: 0 = output A, 1 = output B; qualified by in_valid.
- a_valid  output  1  output A holds a beat.
- a_ready  input  1  consumer A takes the beat this cycle.
- a_data  output  BITS  output A payload.
- b_valid  output  1  output B holds a beat.
- b_ready  input  1  consumer B takes the beat this cycle.
- b_data  output  BITS  output B payload.

## Operation
- State per output X in {A, B}:
  - x_full: 1-bit flag driving x_valid.
  - x_reg: BITS-wide register driving x_data.
- x_free = !x_full || x_ready. The register is empty, or it drains this cycle.
- in_ready = in_select ? b_free : a_free.
  - Purely combinational from in_select, a_full/b_full and a_ready/b_ready.
  - Independent of in_valid.
- accept = in_valid && in_ready.
- Per-output update, each clock edge:
  - Load (accept, and in_select selects X): x_reg <= in_data, x_full <= 1.
  - Drain only (x_full && x_ready, no load into X): x_full <= 0; x_reg holds its value.
  - Drain and load in the same cycle: x_full stays 1 and x_reg takes the new data. This gives a full-throughput pass-through.
  - Otherwise X holds.
- No head-of-line blocking between outputs. A stalled A never blocks beats selected for B, and the reverse.
- A beat selected for a full, non-draining output stalls the input (in_ready = 0).
- Every accepted beat is delivered exactly once to the selected output. No duplication, no loss, no reordering within an output.
- Formal block (FORMAL): assert the following.
  - x_valid && !x_ready at edge N implies x_valid and an unchanged x_data at edge N+1.
  - in_ready matches the formula above.
  - After reset deassertion, a_valid = b_valid = 0 until the first accept.

## Timing
- Reset (reset_n = 0, asynchronous): a_full = b_full = 0 and a_reg = b_reg = 0 immediately. Outputs are therefore a_valid = b_valid = 0 and a_data = b_data = 0.
  - in_ready during reset = 1, because both outputs are free.
- Reset mid-operation: held beats are discarded without handshake; valid drops in the same cycle reset asserts.
- Latency: a beat accepted at edge N is visible on x_valid/x_data from just after edge N. That is one cycle, with no combinational path from in_data to x_data.
- Throughput: one beat per cycle sustained into either output while its consumer holds ready = 1.
- Boundary cases:
  - in_select may change every cycle.
  - in_ready may toggle within a cycle if in_select changes. Producers must hold in_data and in_select stable while in_valid && !in_ready.
  - Both outputs full, both ready, no input: both drain at the same edge and both valid flags clear.
  - in_valid = 0: no state changes except drains.

## Test plan
- Reset: assert reset_n = 0 mid-cycle with a_full = 1. Required: a_valid = 0 and a_data = 0 before the next edge, and in_ready = 1 while held in reset.
- Pass-through: BITS = 8, a_ready = 1, stream 0x01..0x10 with in_select = 0. Required: in_ready is 1 throughout, a_data shows 0x01..0x10 on consecutive cycles each one cycle after acceptance, and b_valid stays 0.
- Independent stall: a_ready = 0. Send 0x11 to A, then 0x22 and 0x33 to B with b_ready = 1, then 0x44 to A. Required:
  - 0x22 and 0x33 pass through B.
  - a_data holds 0x11.
  - in_ready = 0 while 0x44 is offered to A.
  - Raising a_ready yields 0x11, then 0x44 on A.
- Drain-and-load: A full with 0xAA, a_ready = 1, offer 0xBB to A. Required: in_ready = 1, and at the next edge a_valid = 1 with a_data = 0xBB.
- Alternating select with random a_ready/b_ready over 1000 beats. Required:
  - A scoreboard shows A receives exactly the select = 0 beats, in order, and B exactly the select = 1 beats, in order.
  - x_data never changes while x_valid && !x_ready.

Source files
------------

// File: rtl/demux2_buf.sv
// Registered 1:2 stream demultiplexer: each beat is steered by in_select into one
// of two independent one-entry holding registers, so A and B stall separately.
module demux2_buf #(
   parameter int BITS = 1
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [BITS-1:0] in_data,
   input  logic            in_select,
   output logic            a_valid,
   input  logic            a_ready,
   output logic [BITS-1:0] a_data,
   output logic            b_valid,
   input  logic            b_ready,
   output logic [BITS-1:0] b_data
);

   // Handshake contract: a beat moves on any rising edge where valid && ready.
   // in_ready depends only on in_select and the destination's full/ready state,
   // never on in_valid; producers hold data and select while valid && !ready.

   logic            a_full;
   logic            b_full;
   logic [BITS-1:0] a_reg;
   logic [BITS-1:0] b_reg;
   logic            a_free;
   logic            b_free;
   logic            accept;
   logic            a_load;
   logic            b_load;

   // A register is free when it is empty or its consumer takes the beat now.
   assign a_free   = !a_full || a_ready;
   assign b_free   = !b_full || b_ready;
   assign in_ready = in_select ? b_free : a_free;
   assign accept   = in_valid && in_ready;
   assign a_load   = accept && !in_select;
   assign b_load   = accept && in_select;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_full <= 1'b0;
         a_reg  <= '0;
      end else if (a_load) begin
         a_full <= 1'b1;
         a_reg  <= in_data;
      end else if (a_full && a_ready) begin
         a_full <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         b_full <= 1'b0;
         b_reg  <= '0;
      end else if (b_load) begin
         b_full <= 1'b1;
         b_reg  <= in_data;
      end else if (b_full && b_ready) begin
         b_full <= 1'b0;
      end
   end

   assign a_valid = a_full;
   assign a_data  = a_reg;
   assign b_valid = b_full;
   assign b_data  = b_reg;

`ifdef FORMAL
   logic seen_accept;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) seen_accept <= 1'b0;
      else if (accept) seen_accept <= 1'b1;
   end

   a_hold_stable: assert property (@(posedge clk) disable iff (!reset_n)
      a_valid && !a_ready |=> a_valid && $stable(a_data));
   b_hold_stable: assert property (@(posedge clk) disable iff (!reset_n)
      b_valid && !b_ready |=> b_valid && $stable(b_data));
   ready_formula: assert property (@(posedge clk)
      in_ready == (in_select ? (!b_full || b_ready) : (!a_full || a_ready)));
   idle_after_reset: assert property (@(posedge clk) disable iff (!reset_n)
      !seen_accept |-> !a_valid && !b_valid);
`endif

endmodule

// File: tb/tb_demux2_buf.sv
// Bench for demux2_buf: directed scenarios plus a randomized run, with per-output
// expected queues filled on accepted input beats and drained on output handshakes.
module tb_demux2_buf;
   localparam int BITS = 8;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            in_valid;
   logic            in_ready;
   logic [BITS-1:0] in_data;
   logic            in_select;
   logic            a_valid;
   logic            a_ready;
   logic [BITS-1:0] a_data;
   logic            b_valid;
   logic            b_ready;
   logic [BITS-1:0] b_data;

   int n_cmp = 0;
   int n_bad = 0;

   logic [BITS-1:0] a_q[$];
   logic [BITS-1:0] b_q[$];
   logic            a_hold_v = 1'b0;
   logic            b_hold_v = 1'b0;
   logic [BITS-1:0] a_hold_d = '0;
   logic [BITS-1:0] b_hold_d = '0;

   demux2_buf #(.BITS(BITS)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_select(in_select),
      .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data)
   );

   // Clock: rising edges at 5, 15, ...; inputs change just after the falling edge.
   always #5 clk = ~clk;

   // Scoreboard: samples 1 time unit before each rising edge.
   initial begin
      logic [BITS-1:0] exp;
      forever begin
         @(negedge clk);
         #4;
         if (!reset_n) begin
            a_hold_v = 1'b0;
            b_hold_v = 1'b0;
         end else begin
            if (a_hold_v) begin
               n_cmp++;
               if (a_valid !== 1'b1 || a_data !== a_hold_d) begin
                  n_bad++;
                  $display("FAIL a_stall_stable: valid=%b data=%h required valid=1 data=%h", a_valid, a_data, a_hold_d);
               end
            end
            if (b_hold_v) begin
               n_cmp++;
               if (b_valid !== 1'b1 || b_data !== b_hold_d) begin
                  n_bad++;
                  $display("FAIL b_stall_stable: valid=%b data=%h required valid=1 data=%h", b_valid, b_data, b_hold_d);
               end
            end
            if (a_valid && a_ready) begin
               n_cmp++;
               if (a_q.size() == 0) begin
                  n_bad++;
                  $display("FAIL a_scoreboard: got %h, required no beat", a_data);
               end else begin
                  exp = a_q.pop_front();
                  if (a_data !== exp) begin
                     n_bad++;
                     $display("FAIL a_scoreboard: got %h, required %h", a_data, exp);
                  end
               end
            end
            if (b_valid && b_ready) begin
               n_cmp++;
               if (b_q.size() == 0) begin
                  n_bad++;
                  $display("FAIL b_scoreboard: got %h, required no beat", b_data);
               end else begin
                  exp = b_q.pop_front();
                  if (b_data !== exp) begin
                     n_bad++;
                     $display("FAIL b_scoreboard: got %h, required %h", b_data, exp);
                  end
               end
            end
            a_hold_v = a_valid && !a_ready;
            a_hold_d = a_data;
            b_hold_v = b_valid && !b_ready;
            b_hold_d = b_data;
            if (in_valid && in_ready) begin
               if (in_select) b_q.push_back(in_data);
               else a_q.push_back(in_data);
            end
         end
      end
   end

   // Offer one beat, hold it until accepted (bounded), return cycles spent waiting.
   task automatic send(input logic [BITS-1:0] d, input logic sel, output int waits);
      waits = 0;
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = d;
      in_select = sel;
      #4;
      while (!in_ready && waits < 50) begin
         @(negedge clk);
         #4;
         waits++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain_all();
      @(negedge clk);
      in_valid = 1'b0;
      a_ready  = 1'b1;
      b_ready  = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      reset_n   = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_select = 1'b0;
      a_ready   = 1'b0;
      b_ready   = 1'b0;
      #1 reset_n = 1'b0;
      #2;
      n_cmp++;
      if ({a_valid, b_valid, a_data, b_data, in_ready} !== {2'b00, 16'h0000, 1'b1}) begin
         n_bad++;
         $display("FAIL reset_state: av=%b bv=%b ad=%h bd=%h ir=%b required 0 0 00 00 1",
                  a_valid, b_valid, a_data, b_data, in_ready);
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         #1;
         n_cmp++;
         if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: av=%b bv=%b required 0 0", a_valid, b_valid);
         end
      end
   endtask

   task automatic test_reset_mid_op();
      int w;
      a_ready = 1'b0;
      send(8'h5A, 1'b0, w);
      @(negedge clk);
      n_cmp++;
      if (a_valid !== 1'b1 || a_data !== 8'h5A) begin
         n_bad++;
         $display("FAIL pre_reset_full: av=%b ad=%h required 1 5a", a_valid, a_data);
      end
      #2;
      reset_n = 1'b0;
      a_q.delete();
      b_q.delete();
      #1;
      n_cmp++;
      if (a_valid !== 1'b0 || a_data !== 8'h00 || in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL mid_op_reset: av=%b ad=%h ir=%b required 0 00 1", a_valid, a_data, in_ready);
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_pass_through();
      int w;
      a_ready = 1'b1;
      b_ready = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         send(i[BITS-1:0], 1'b0, w);
         n_cmp++;
         if (w != 0) begin
            n_bad++;
            $display("FAIL pt_in_ready: beat %0d waited %0d cycles, required 0", i, w);
         end
         n_cmp++;
         if (a_valid !== 1'b1 || a_data !== i[BITS-1:0] || b_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL pt_output: av=%b ad=%h bv=%b required 1 %h 0", a_valid, a_data, b_valid, i[BITS-1:0]);
         end
      end
      drain_all();
   endtask

   task automatic test_independent_stall();
      int w;
      a_ready = 1'b0;
      b_ready = 1'b1;
      send(8'h11, 1'b0, w);
      send(8'h22, 1'b1, w);
      n_cmp++;
      if (b_valid !== 1'b1 || b_data !== 8'h22 || w != 0) begin
         n_bad++;
         $display("FAIL stall_b_22: bv=%b bd=%h waits=%0d required 1 22 0", b_valid, b_data, w);
      end
      send(8'h33, 1'b1, w);
      n_cmp++;
      if (b_valid !== 1'b1 || b_data !== 8'h33 || w != 0) begin
         n_bad++;
         $display("FAIL stall_b_33: bv=%b bd=%h waits=%0d required 1 33 0", b_valid, b_data, w);
      end
      n_cmp++;
      if (a_valid !== 1'b1 || a_data !== 8'h11) begin
         n_bad++;
         $display("FAIL stall_a_hold: av=%b ad=%h required 1 11", a_valid, a_data);
      end
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = 8'h44;
      in_select = 1'b0;
      repeat (3) begin
         #4;
         n_cmp++;
         if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_in_ready: got %b required 0", in_ready);
         end
         @(negedge clk);
      end
      a_ready = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1 || a_data !== 8'h11) begin
         n_bad++;
         $display("FAIL release_a: ir=%b ad=%h required 1 11", in_ready, a_data);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n_cmp++;
      if (a_valid !== 1'b1 || a_data !== 8'h44) begin
         n_bad++;
         $display("FAIL release_a_44: av=%b ad=%h required 1 44", a_valid, a_data);
      end
      drain_all();
   endtask

   task automatic test_drain_and_load();
      int w;
      a_ready = 1'b0;
      send(8'hAA, 1'b0, w);
      @(negedge clk);
      a_ready   = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'hBB;
      in_select = 1'b0;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL dl_in_ready: got %b required 1", in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n_cmp++;
      if (a_valid !== 1'b1 || a_data !== 8'hBB) begin
         n_bad++;
         $display("FAIL dl_output: av=%b ad=%h required 1 bb", a_valid, a_data);
      end
      drain_all();
   endtask

   task automatic test_both_drain();
      int w;
      a_ready = 1'b0;
      b_ready = 1'b0;
      send(8'hC1, 1'b0, w);
      send(8'hC2, 1'b1, w);
      n_cmp++;
      if (a_valid !== 1'b1 || b_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL both_full: av=%b bv=%b required 1 1", a_valid, b_valid);
      end
      @(negedge clk);
      a_ready = 1'b1;
      b_ready = 1'b1;
      @(posedge clk);
      #1;
      n_cmp++;
      if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL both_drain: av=%b bv=%b required 0 0", a_valid, b_valid);
      end
   endtask

   task automatic test_random();
      int  beats = 0;
      int  cycles = 0;
      logic acc;
      in_valid = 1'b0;
      while ((beats < 1000 || in_valid) && cycles < 20000) begin
         @(negedge clk);
         a_ready = ($urandom_range(0, 9) < 6);
         b_ready = ($urandom_range(0, 9) < 6);
         if (!in_valid && beats < 1000 && $urandom_range(0, 3) != 0) begin
            in_valid  = 1'b1;
            in_data   = BITS'($urandom_range(0, 255));
            in_select = beats[0];
            beats++;
         end
         #4;
         acc = in_valid && in_ready;
         @(posedge clk);
         #1;
         if (acc) in_valid = 1'b0;
         cycles++;
      end
      n_cmp++;
      if (cycles >= 20000) begin
         n_bad++;
         $display("FAIL random_budget: sent %0d beats in %0d cycles, required 1000", beats, cycles);
      end
      drain_all();
      n_cmp++;
      if (a_q.size() != 0 || b_q.size() != 0 || a_valid !== 1'b0 || b_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL random_leftover: a_q=%0d b_q=%0d av=%b bv=%b required 0 0 0 0",
                  a_q.size(), b_q.size(), a_valid, b_valid);
      end
   endtask

   initial begin
      test_reset();
      test_reset_mid_op();
      test_pass_through();
      test_independent_stall();
      test_drain_and_load();
      test_both_drain();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
